// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, status bit
// positions, FSM state encoding and the baud divider calculation.
package uart_pkg;

    localparam logic [3:0] UART_RECV   = 4'h4;
    localparam logic [3:0] UART_SEND   = 4'h8;
    localparam logic [3:0] UART_STATUS = 4'hC;

    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, start-bit glitch rejection, mid-bit sampling,
// one-cycle o_done pulse with the byte on o_data when the stop bit is valid.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk_bus,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_done
);

    localparam int                CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(DIV - 1);

    uart_state_t      r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_bit, w_bit_n;
    logic [7:0]       r_shift, w_shift_n;
    logic [1:0]       r_sync;
    logic             r_prev;
    logic             r_done, w_done_n;
    logic             w_line, w_fall, w_tc;

    assign w_line = r_sync[1];
    assign w_fall = r_prev & ~w_line;
    assign w_tc   = (r_cnt == '0);

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rxd};
            r_prev  <= w_line;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_tc ? r_cnt : r_cnt - CNT_W'(1);
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_n = S_START;
                    w_cnt_n   = HALF_M1;
                end
            end
            S_START: begin
                // Line back high at mid-start means it was only a glitch.
                if (w_tc) begin
                    if (w_line) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_DATA;
                        w_cnt_n   = FULL_M1;
                        w_bit_n   = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    w_shift_n = {w_line, r_shift[7:1]};
                    w_cnt_n   = FULL_M1;
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tc) begin
                    w_state_n = S_IDLE;
                    w_done_n  = w_line;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign o_data = r_shift;
    assign o_done = r_done;

endmodule

// File: rtl/uart_bus_top.sv
// Memory-mapped 8N1 UART: register file, transmitter and baud divider, with the
// receiver in uart_rx. Registers: RECV 0x4, SEND 0x8, STATUS 0xC (W1C).
module uart_bus_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk_bus,
    input  logic        rst,
    input  logic [3:0]  bus_address,
    input  logic [31:0] bus_data_i,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_data_o,
    input  logic        rxd,
    output logic        txd
);

    localparam int               DIV     = calc_div(CLK_FREQ, BAUD);
    localparam int               CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

    uart_state_t      r_tx_state, w_tx_state_n;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]       r_tx_bit, w_tx_bit_n;
    logic [7:0]       r_tx_shift, w_tx_shift_n;
    logic             r_txd, w_txd_n;
    logic             w_tx_tc, w_tx_ready, w_send;

    logic [7:0]       r_rx_byte;
    logic             r_rx_valid, r_rx_overrun;
    logic [7:0]       w_rx_data;
    logic             w_rx_done;
    logic             w_status_wr;
    logic             w_unused_bits;

    assign w_tx_tc     = (r_tx_cnt == '0);
    // Ready already in the last stop-bit cycle so back-to-back frames are exactly 10*DIV.
    assign w_tx_ready  = (r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_tc);
    assign w_send      = bus_write && (bus_address == UART_SEND) && w_tx_ready;
    assign w_status_wr = bus_write && (bus_address == UART_STATUS);

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_txd      <= w_txd_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = w_tx_tc ? r_tx_cnt : r_tx_cnt - CNT_W'(1);
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_txd_n      = r_txd;
        if (w_send) begin
            w_tx_state_n = S_START;
            w_tx_cnt_n   = FULL_M1;
            w_tx_shift_n = bus_data_i[7:0];
            w_txd_n      = 1'b0;
        end else if (w_tx_tc) begin
            case (r_tx_state)
                S_START: begin
                    w_tx_state_n = S_DATA;
                    w_tx_cnt_n   = FULL_M1;
                    w_tx_bit_n   = '0;
                    w_txd_n      = r_tx_shift[0];
                end
                S_DATA: begin
                    w_tx_cnt_n = FULL_M1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = S_STOP;
                        w_txd_n      = 1'b1;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_txd_n      = r_tx_shift[1];
                    end
                end
                S_STOP: begin
                    w_tx_state_n = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign txd = r_txd;

    uart_rx #(
        .DIV(DIV)
    ) u_rx (
        .clk_bus(clk_bus),
        .rst    (rst),
        .i_rxd  (rxd),
        .o_data (w_rx_data),
        .o_done (w_rx_done)
    );

    // A completing frame takes priority over a same-cycle W1C clear.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_done) begin
                r_rx_byte <= w_rx_data;
            end
            if (w_rx_done) begin
                r_rx_valid <= 1'b1;
            end else if (w_status_wr && bus_data_i[ST_RX_VALID]) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_done && r_rx_valid) begin
                r_rx_overrun <= 1'b1;
            end else if (w_status_wr && bus_data_i[ST_RX_OVERRUN]) begin
                r_rx_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        bus_data_o = '0;
        if (bus_read) begin
            case (bus_address)
                UART_RECV: bus_data_o = {24'b0, r_rx_byte};
                UART_STATUS: begin
                    bus_data_o[ST_TX_READY]   = w_tx_ready;
                    bus_data_o[ST_RX_VALID]   = r_rx_valid;
                    bus_data_o[ST_RX_OVERRUN] = r_rx_overrun;
                end
                default: bus_data_o = '0;
            endcase
        end
    end

    assign w_unused_bits = &{1'b0, bus_data_i[31:8], bus_data_i[0]};

endmodule

// File: tb/tb_uart_bus_top.sv
// Directed self-checking bench for uart_bus_top, run with a divider of 16
// and txd looped back to rxd except during the glitch scenario.
module tb_uart_bus_top;

    localparam int         DIV      = 16;
    localparam logic [3:0] A_RSVD   = 4'h0;
    localparam logic [3:0] A_RECV   = 4'h4;
    localparam logic [3:0] A_SEND   = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hC;

    logic        clk_bus = 1'b0;
    logic        rst;
    logic [3:0]  bus_address;
    logic [31:0] bus_data_i;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_data_o;
    logic        rxd;
    logic        txd;
    logic        loop_en;
    logic        rxd_drv;

    int n_checks = 0;
    int n_pass   = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk_bus = ~clk_bus;

    uart_bus_top #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .clk_bus    (clk_bus),
        .rst        (rst),
        .bus_address(bus_address),
        .bus_data_i (bus_data_i),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .bus_data_o (bus_data_o),
        .rxd        (rxd),
        .txd        (txd)
    );

    // All bus tasks are entered at (or just after) a falling edge.
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        bus_address = a;
        bus_data_i  = d;
        bus_write   = 1'b1;
        @(negedge clk_bus);
        bus_write   = 1'b0;
        bus_data_i  = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        bus_address = a;
        bus_read    = 1'b1;
        #1;
        d           = bus_data_o;
        bus_read    = 1'b0;
    endtask

    task automatic wait_status(input int bitn, input logic val, input int budget, output logic ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            bus_rd(A_STATUS, s);
            if (s[bitn] === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_bus);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int bad;
        bad = 0;
        repeat (5) begin
            @(negedge clk_bus);
            if (txd !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL reset_txd: %0d cycles with txd!=1, required 0", bad);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk_bus);
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL reset_status: got %h required %h", d, 32'h1);
        else n_pass++;
        bus_rd(A_RECV, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_recv: got %h required %h", d, 32'h0);
        else n_pass++;
        bus_rd(A_RSVD, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reserved_read: got %h required %h", d, 32'h0);
        else n_pass++;
        bus_address = A_STATUS;
        #1;
        n_checks++;
        if (bus_data_o !== 32'h0) $display("FAIL idle_read_zero: got %h required %h", bus_data_o, 32'h0);
        else n_pass++;
    endtask

    task automatic test_loopback_aa;
        logic [31:0] d;
        logic [7:0]  tx_byte;
        logic        exp_bit;
        int          bad, e_ready, e_valid, idx;
        tx_byte = 8'hAA;
        bad = 0; e_ready = -1; e_valid = -1;
        @(negedge clk_bus);
        bus_wr(A_SEND, {24'b0, tx_byte});
        n_checks++;
        if (txd !== 1'b0) $display("FAIL tx_start_bit: txd=%b required 0", txd);
        else n_pass++;
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d[0] !== 1'b0) $display("FAIL tx_busy: ready=%b required 0", d[0]);
        else n_pass++;
        for (int e = 1; e <= 10 * DIV + 4; e++) begin
            @(negedge clk_bus);
            if ((e % DIV == DIV / 2) && (e < 10 * DIV)) begin
                idx = e / DIV;
                if (idx == 0) exp_bit = 1'b0;
                else if (idx == 9) exp_bit = 1'b1;
                else exp_bit = tx_byte[idx-1];
                if (txd !== exp_bit) bad++;
            end
            bus_rd(A_STATUS, d);
            if (d[0] === 1'b1 && e_ready < 0) e_ready = e;
            if (d[1] === 1'b1 && e_valid < 0) e_valid = e;
        end
        n_checks++;
        if (bad != 0) $display("FAIL tx_frame_bits: %0d wrong mid-bit samples, required 0", bad);
        else n_pass++;
        n_checks++;
        if (e_ready != 10 * DIV - 1) $display("FAIL tx_ready_time: cycle %0d required %0d", e_ready, 10 * DIV - 1);
        else n_pass++;
        n_checks++;
        if (e_valid < 0) $display("FAIL rx_valid_timeout: not set within %0d cycles", 10 * DIV + 4);
        else n_pass++;
        bus_rd(A_RECV, d);
        n_checks++;
        if (d !== 32'h0000_00AA) $display("FAIL recv_aa: got %h required %h", d, 32'h0000_00AA);
        else n_pass++;
        bus_wr(A_STATUS, 32'h2);
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL clear_valid: status %h required %h", d, 32'h1);
        else n_pass++;
    endtask

    task automatic test_sequence;
        logic [7:0]  seq [7] = '{8'h00, 8'h55, 8'hFF, 8'h01, 8'h80, 8'h92, 8'hA7};
        logic [31:0] d;
        logic        ok1, ok2;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_bus);
            wait_status(0, 1'b1, 12 * DIV, ok1);
            bus_wr(A_SEND, {24'b0, seq[k]});
            wait_status(1, 1'b1, 11 * DIV, ok2);
            n_checks++;
            if (!(ok1 && ok2)) $display("FAIL seq_timeout[%0d]: ready_ok=%b valid_ok=%b required 1 1", k, ok1, ok2);
            else n_pass++;
            bus_rd(A_RECV, d);
            n_checks++;
            if (d !== {24'b0, seq[k]}) $display("FAIL seq_recv[%0d]: got %h required %h", k, d, {24'b0, seq[k]});
            else n_pass++;
            bus_rd(A_STATUS, d);
            n_checks++;
            if (d[2] !== 1'b0) $display("FAIL seq_overrun[%0d]: got %b required 0", k, d[2]);
            else n_pass++;
            @(negedge clk_bus);
            bus_wr(A_STATUS, 32'h2);
        end
    endtask

    task automatic test_busy_write;
        logic [31:0] d;
        logic        ok;
        int          seen;
        @(negedge clk_bus);
        wait_status(0, 1'b1, 12 * DIV, ok);
        bus_wr(A_SEND, 32'h3C);
        repeat (20) @(negedge clk_bus);
        bus_wr(A_SEND, 32'hC3);
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d[0] !== 1'b0) $display("FAIL busy_still_busy: ready=%b required 0", d[0]);
        else n_pass++;
        @(negedge clk_bus);
        wait_status(1, 1'b1, 11 * DIV, ok);
        bus_rd(A_RECV, d);
        n_checks++;
        if (!ok || d !== 32'h3C) $display("FAIL busy_recv: valid_ok=%b got %h required %h", ok, d, 32'h3C);
        else n_pass++;
        @(negedge clk_bus);
        bus_wr(A_STATUS, 32'h2);
        seen = 0;
        repeat (12 * DIV) begin
            bus_rd(A_STATUS, d);
            if (d[1] === 1'b1) seen++;
            @(negedge clk_bus);
        end
        n_checks++;
        if (seen != 0) $display("FAIL busy_no_second_frame: valid seen %0d cycles, required 0", seen);
        else n_pass++;
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        logic        ok;
        int          seen;
        @(negedge clk_bus);
        wait_status(0, 1'b1, 12 * DIV, ok);
        @(negedge clk_bus);
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        repeat (2 * DIV) @(negedge clk_bus);
        rxd_drv = 1'b0;
        repeat (DIV / 4) @(negedge clk_bus);
        rxd_drv = 1'b1;
        seen = 0;
        repeat (12 * DIV) begin
            bus_rd(A_STATUS, d);
            if (d[1] === 1'b1) seen++;
            @(negedge clk_bus);
        end
        n_checks++;
        if (seen != 0) $display("FAIL glitch_rejected: valid seen %0d cycles, required 0", seen);
        else n_pass++;
        loop_en = 1'b1;
        repeat (4) @(negedge clk_bus);
        bus_wr(A_SEND, 32'h5A);
        wait_status(1, 1'b1, 11 * DIV, ok);
        bus_rd(A_RECV, d);
        n_checks++;
        if (!ok || d !== 32'h5A) $display("FAIL glitch_then_frame: valid_ok=%b got %h required %h", ok, d, 32'h5A);
        else n_pass++;
        @(negedge clk_bus);
        bus_wr(A_STATUS, 32'h2);
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        logic        ok1, ok2, ok3, ok4;
        @(negedge clk_bus);
        wait_status(0, 1'b1, 12 * DIV, ok1);
        bus_wr(A_SEND, 32'h11);
        wait_status(1, 1'b1, 11 * DIV, ok2);
        @(negedge clk_bus);
        wait_status(0, 1'b1, 2 * DIV, ok3);
        bus_wr(A_SEND, 32'h22);
        wait_status(2, 1'b1, 11 * DIV, ok4);
        n_checks++;
        if (!(ok1 && ok2 && ok3 && ok4)) $display("FAIL overrun_timeout: flags %b%b%b%b required 1111", ok1, ok2, ok3, ok4);
        else n_pass++;
        @(negedge clk_bus);
        wait_status(0, 1'b1, 2 * DIV, ok1);
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h7) $display("FAIL overrun_status: got %h required %h", d, 32'h7);
        else n_pass++;
        bus_rd(A_RECV, d);
        n_checks++;
        if (d !== 32'h22) $display("FAIL overrun_recv: got %h required %h", d, 32'h22);
        else n_pass++;
        @(negedge clk_bus);
        bus_wr(A_STATUS, 32'h6);
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL overrun_clear: got %h required %h", d, 32'h1);
        else n_pass++;
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        logic        ok;
        int          seen;
        @(negedge clk_bus);
        wait_status(0, 1'b1, 12 * DIV, ok);
        bus_wr(A_SEND, 32'h66);
        seen = 0;
        // Clear every cycle; the completing frame must still show valid for one cycle.
        for (int e = 0; e < 11 * DIV; e++) begin
            bus_address = A_STATUS;
            bus_data_i  = 32'h2;
            bus_write   = 1'b1;
            bus_read    = 1'b1;
            #1;
            if (bus_data_o[1] === 1'b1) seen++;
            bus_read    = 1'b0;
            @(negedge clk_bus);
        end
        bus_write  = 1'b0;
        bus_data_i = '0;
        n_checks++;
        if (seen != 1) $display("FAIL set_wins_valid: valid seen %0d cycles, required 1", seen);
        else n_pass++;
        bus_rd(A_RECV, d);
        n_checks++;
        if (d !== 32'h66) $display("FAIL set_wins_recv: got %h required %h", d, 32'h66);
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        logic        ok;
        int          bad;
        @(negedge clk_bus);
        wait_status(0, 1'b1, 12 * DIV, ok);
        bus_wr(A_SEND, 32'hF0);
        repeat (3 * DIV) @(negedge clk_bus);
        n_checks++;
        if (txd !== 1'b0) $display("FAIL midframe_txd_low: txd=%b required 0", txd);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1) $display("FAIL reset_txd_immediate: txd=%b required 1", txd);
        else n_pass++;
        @(negedge clk_bus);
        rst = 1'b0;
        @(negedge clk_bus);
        bus_rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL midframe_status: got %h required %h", d, 32'h1);
        else n_pass++;
        bus_rd(A_RECV, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL midframe_recv: got %h required %h", d, 32'h0);
        else n_pass++;
        bad = 0;
        repeat (12 * DIV) begin
            @(negedge clk_bus);
            bus_rd(A_STATUS, d);
            if (d !== 32'h1 || txd !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL midframe_quiet: %0d disturbed cycles, required 0", bad);
        else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        loop_en     = 1'b1;
        rxd_drv     = 1'b1;
        bus_address = '0;
        bus_data_i  = '0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        test_reset();
        test_loopback_aa();
        test_sequence();
        test_busy_write();
        test_glitch();
        test_overrun();
        test_set_wins();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/uart_bus_top.md
# uart_bus_top

Memory-mapped 8N1 UART peripheral on the CPU's simple synchronous bus. It holds one transmit byte and one receive byte, and exposes them through three 32-bit registers (receive, send, status). Bit timing comes from a fixed divider of the single bus clock. It sits between the bus decoder and the board serial pins `txd`/`rxd`.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: bus clock frequency in Hz.
- `BAUD`, default 115200: line rate; divider `DIV = round(CLK_FREQ/BAUD)` (434 at defaults).

Ports (one clock; reset is asynchronous and active-high):
- `clk_bus` in 1: bus/system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bus_address` in 4: byte offset of the register.
- `bus_data_i` in 32: write data.
- `bus_read` in 1: read strobe.
- `bus_write` in 1: write strobe, one cycle per access.
- `bus_data_o` out 32: read data.
- `rxd` in 1: serial input, asynchronous to `clk_bus`.
- `txd` out 1: serial output, idles high.

## Operation
Register map:
- 0x0: reserved. Reads 0, writes ignored.
- 0x4 RECV: read gives `{24'b0, rx_byte}`. Reading does not clear `rx_valid`.
- 0x8 SEND: write `bus_data_i[7:0]` to start a frame. The write is ignored while the transmitter is busy.
- 0xC STATUS, read: bit0 `tx_ready` (transmitter idle), bit1 `rx_valid`, bit2 `rx_overrun`, other bits 0.
- 0xC STATUS, write: write-1-to-clear. Bit1 clears `rx_valid`, bit2 clears `rx_overrun`, bit0 is ignored.

Read path:
- `bus_data_o` is combinational from `bus_address` while `bus_read`=1, and 0 otherwise.

Transmitter:
- States IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
- Each state/bit lasts exactly `DIV` clocks.

Receiver:
- `rxd` passes through a 2-FF synchronizer.
- IDLE: a falling edge starts the DIV counter.
- At DIV/2, if the line is high again the event is a glitch and the receiver returns to IDLE.
- Otherwise it samples 8 data bits, each at mid-bit, LSB first, then checks the stop bit at mid-bit.
- Stop=1: load `rx_byte`; if `rx_valid` was already 1, set `rx_overrun`; then set `rx_valid`.
- Stop=0 (framing error): discard the byte; no flags change.
- The receiver returns to IDLE after the stop-bit sample.

## Timing
Reset values:
- `txd`=1, `tx_ready`=1, `rx_valid`=0, `rx_overrun`=0, `rx_byte`=0, both FSMs in IDLE.
- `bus_data_o` follows the combinational rule above.

Transmit:
- A SEND write at edge N sets `tx_ready`=0 and drives `txd`=0 from edge N.
- A full frame is 10·DIV clocks.
- `tx_ready` returns to 1 at the end of the stop bit, and a new SEND is accepted in that same cycle.

Receive:
- `rx_valid` rises about 9.5·DIV + 2 clocks after the start-bit falling edge on `rxd`.

Boundary conditions:
- A frame completing in the same cycle as a STATUS write clearing `rx_valid`: set wins, so `rx_valid` stays 1.
- Reset mid-frame: both FSMs abort, `txd` goes to 1 immediately, and any partial byte is lost.

## Structure
- Package `uart_pkg`:
  - register offsets `UART_RECV`=4'h4, `UART_SEND`=4'h8, `UART_STATUS`=4'hC;
  - status bit indices;
  - FSM state enum.
- One sub-module: `uart_rx` (synchronizer, FSM, byte output plus one-cycle `done` pulse).
- The transmitter, divider and register file stay in the top module.

## Test plan
- Reset, then read STATUS → 0x1; `txd`=1 throughout reset.
- Loop `txd` back to `rxd`, write SEND 0xAA → after at most 10·DIV+4 clocks STATUS bit1=1 and RECV reads 0x000000AA; write STATUS 0x2 → STATUS bit1=0.
- Looped sequence 0x00, 0x55, 0xFF, 0x01, 0x80, 0x92, 0xA7, each sent after polling `tx_ready` → each received byte matches in order, no overrun.
- Write SEND while `tx_ready`=0 → ignored; the in-flight frame is unchanged and the next received byte is the original.
- Pulse `rxd` low for DIV/4 clocks while idle → no frame, `rx_valid` stays 0.
- Receive two bytes without clearing → STATUS=0x7 and RECV holds the second byte; write STATUS 0x6 → STATUS=0x1.
